// File: rtl/kgprisc_boot_loader.sv
// kgprisc_boot_loader: streams a program image into KGPRISC instruction memory
// over a valid/ready port, then releases the core from reset.
//
// Optional build macro: KGPRISC_LOADER_CHECKSUM_EN
//   When defined, the beat that follows the in_last beat is a checksum word
//   (32-bit sum of all written words). It is not written to memory. A match
//   releases the core; a mismatch latches err.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   start           single-cycle pulse, begins a (re)load from IDLE or RUN
//   in_valid/in_data/in_last/in_ready   image stream (valid/ready)
//   imem_we/imem_addr/imem_wdata        instruction-memory write port (registered)
//   cpu_rst         core reset, 1 = held
//   load_done       image loaded, core running
//   err             overflow or checksum failure, sticky until rst
//   word_count      words written in the current/last load, saturates at DEPTH
module kgprisc_boot_loader #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RST_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_HOLD = 3'd2,
        S_RUN  = 3'd3,
        S_ERR  = 3'd4
`ifdef KGPRISC_LOADER_CHECKSUM_EN
        ,
        S_CHK  = 3'd5
`endif
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   ptr, ptr_nxt;
    logic [CNT_W-1:0]    wc_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic                we_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   wdata_nxt;
    logic                cpu_rst_nxt;
    logic                load_done_nxt;
    logic                err_nxt;
`ifdef KGPRISC_LOADER_CHECKSUM_EN
    logic [31:0]         sum_q, sum_nxt;
`endif

    // Ready is a pure function of state so the source sees it without a cycle of lag
    always_comb begin
        in_ready = (state == S_LOAD);
`ifdef KGPRISC_LOADER_CHECKSUM_EN
        if (state == S_CHK) in_ready = 1'b1;
`endif
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= '0;
            hold_cnt   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rst    <= 1'b1;
            load_done  <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
`ifdef KGPRISC_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            hold_cnt   <= hold_nxt;
            imem_we    <= we_nxt;
            imem_addr  <= addr_nxt;
            imem_wdata <= wdata_nxt;
            cpu_rst    <= cpu_rst_nxt;
            load_done  <= load_done_nxt;
            err        <= err_nxt;
            word_count <= wc_nxt;
`ifdef KGPRISC_LOADER_CHECKSUM_EN
            sum_q      <= sum_nxt;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        hold_nxt      = hold_cnt;
        we_nxt        = 1'b0;
        addr_nxt      = imem_addr;
        wdata_nxt     = imem_wdata;
        cpu_rst_nxt   = cpu_rst;
        load_done_nxt = load_done;
        err_nxt       = err;
        wc_nxt        = word_count;
`ifdef KGPRISC_LOADER_CHECKSUM_EN
        sum_nxt       = sum_q;
`endif
        case (state)
            S_IDLE, S_RUN: begin
                if (start) begin
                    state_nxt     = S_LOAD;
                    ptr_nxt       = '0;
                    wc_nxt        = '0;
                    cpu_rst_nxt   = 1'b1;
                    load_done_nxt = 1'b0;
`ifdef KGPRISC_LOADER_CHECKSUM_EN
                    sum_nxt       = '0;
`endif
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    we_nxt    = 1'b1;
                    addr_nxt  = ptr;
                    wdata_nxt = in_data;
                    if (word_count != CNT_W'(DEPTH)) wc_nxt = word_count + CNT_W'(1);
`ifdef KGPRISC_LOADER_CHECKSUM_EN
                    sum_nxt   = sum_q + 32'(in_data);
`endif
                    if (in_last) begin
`ifdef KGPRISC_LOADER_CHECKSUM_EN
                        state_nxt = S_CHK;
`else
                        state_nxt = S_HOLD;
                        hold_nxt  = HOLD_W'(RST_HOLD - 1);
`endif
                    end else if (&ptr) begin
                        // Image larger than memory: stop rather than wrap
                        state_nxt = S_ERR;
                        err_nxt   = 1'b1;
                    end else begin
                        ptr_nxt = ptr + ADDR_W'(1);
                    end
                end
            end
`ifdef KGPRISC_LOADER_CHECKSUM_EN
            S_CHK: begin
                // One checksum beat, never written; in_last is don't-care here
                if (in_valid) begin
                    if (32'(in_data) == sum_q) begin
                        state_nxt = S_HOLD;
                        hold_nxt  = HOLD_W'(RST_HOLD - 1);
                    end else begin
                        state_nxt = S_ERR;
                        err_nxt   = 1'b1;
                    end
                end
            end
`endif
            S_HOLD: begin
                if (hold_cnt == '0) begin
                    state_nxt     = S_RUN;
                    cpu_rst_nxt   = 1'b0;
                    load_done_nxt = 1'b1;
                end else begin
                    hold_nxt = hold_cnt - HOLD_W'(1);
                end
            end
            S_ERR: begin
                cpu_rst_nxt = 1'b1;
                err_nxt     = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
